// File: rtl/pic_pkg.sv
// Shared definitions for the Wishbone programmable interrupt controller.
// Contents: register word offsets, the specific-EOI flag position,
// the default vector base and the id reported on a spurious acknowledge.
package pic_pkg;

    typedef enum logic [1:0] {
        REG_IRR = 2'd0,
        REG_ISR = 2'd1,
        REG_IMR = 2'd2,
        REG_EOI = 2'd3
    } reg_off_e;

    localparam int unsigned EOI_SPECIFIC_BIT    = 15;
    localparam logic [4:0]  DEFAULT_VECTOR_BASE = 5'b00001;
    localparam logic [2:0]  SPURIOUS_ID         = 3'b111;

endpackage

// File: rtl/wb_pic_if.sv
// Wishbone slave bus bundle for wb_pic.
// Signals keep their original names, so the _i/_o suffixes are from the
// controller's point of view.
//   wb_adr_i  [1:0]  word select
//   wb_dat_i  [15:0] write data
//   wb_dat_o  [15:0] read data
//   wb_we_i, wb_stb_i, wb_cyc_i  bus controls
//   wb_ack_o         acknowledge
interface wb_pic_if;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/pic_prio_enc.sv
// Lowest-index-first priority encoder.
//   req   [WIDTH-1:0]  request bits, bit 0 has the highest priority
//   valid              at least one request bit is set
//   id    [2:0]        index of the highest-priority set bit (0 when !valid)
module pic_prio_enc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [2:0]       id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!valid && req[i]) begin
                valid = 1'b1;
                id    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/wb_pic.sv
// Wishbone programmable interrupt controller (8259-style, edge triggered).
//   wb_clk_i / wb_rst_i  clock, synchronous active-high reset
//   bus                  Wishbone slave: IRR(0,ro) ISR(1,ro) IMR(2,rw) EOI(3,wo)
//   irq_i                interrupt lines, rising-edge sensitive, bit 0 highest
//   intr_o               registered interrupt request to the CPU
//   inta_i               acknowledge level from the CPU; its rising edge
//                        selects and latches a vector
//   vector_o             {VECTOR_BASE, id}, id = 3'b111 on a spurious acknowledge
module wb_pic
    import pic_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 2,
    parameter logic [4:0]  VECTOR_BASE = DEFAULT_VECTOR_BASE,
    parameter bit          AUTO_EOI    = 1'b0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_pic_if.slave            bus,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               intr_o,
    input  logic               inta_i,
    output logic [7:0]         vector_o
);

    logic [NUM_IRQ-1:0] irr_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [NUM_IRQ-1:0] imr_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic               inta_q;
    logic               ack_q;
    logic               intr_q;
    logic [7:0]         vector_q;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] prio_mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] isr_set;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic [NUM_IRQ-1:0] irr_d;
    logic [NUM_IRQ-1:0] isr_d;
    logic               inta_rise;
    logic               elig_valid;
    logic [2:0]         elig_id;
    logic               isr_valid;
    logic [2:0]         isr_id;
    logic               bus_write;
    reg_off_e           reg_sel;
    logic               unused_dat;

    // Highest in-service level: used both to gate nesting and as the target
    // of a non-specific EOI.
    pic_prio_enc #(.WIDTH(NUM_IRQ)) u_isr_enc (
        .req   (isr_q),
        .valid (isr_valid),
        .id    (isr_id)
    );

    pic_prio_enc #(.WIDTH(NUM_IRQ)) u_ack_enc (
        .req   (eligible),
        .valid (elig_valid),
        .id    (elig_id)
    );

    assign reg_sel    = reg_off_e'(bus.wb_adr_i);
    assign unused_dat = ^bus.wb_dat_i;

    always_comb begin
        irq_rise  = irq_i & ~irq_q;
        inta_rise = inta_i & ~inta_q;
        prio_mask = '0;
        // Only levels strictly above the highest in-service one may interrupt.
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            prio_mask[i] = !isr_valid || (3'(i) < isr_id);
        end
        eligible = irr_q & ~imr_q & prio_mask;
    end

    always_comb begin
        bus_write = ack_q & bus.wb_stb_i & bus.wb_cyc_i & bus.wb_we_i;
        ack_clr   = '0;
        isr_set   = '0;
        eoi_clr   = '0;

        if (inta_rise && elig_valid) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (elig_id == 3'(i)) begin
                    ack_clr[i] = 1'b1;
                    isr_set[i] = !AUTO_EOI;
                end
            end
        end

        if (bus_write && reg_sel == REG_EOI) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (bus.wb_dat_i[EOI_SPECIFIC_BIT]) begin
                    // Indices outside the implemented range match nothing.
                    eoi_clr[i] = (bus.wb_dat_i[2:0] == 3'(i));
                end else begin
                    eoi_clr[i] = isr_valid && (isr_id == 3'(i));
                end
            end
        end

        // A fresh edge beats the acknowledge clear; an acknowledge set of
        // one level and an EOI clear of another land together.
        irr_d = (irr_q & ~ack_clr) | irq_rise;
        isr_d = (isr_q & ~eoi_clr) | isr_set;
    end

    always_comb begin
        bus.wb_dat_o = '0;
        case (reg_sel)
            REG_IRR: bus.wb_dat_o[NUM_IRQ-1:0] = irr_q;
            REG_ISR: bus.wb_dat_o[NUM_IRQ-1:0] = isr_q;
            REG_IMR: bus.wb_dat_o[NUM_IRQ-1:0] = imr_q;
            default: bus.wb_dat_o = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irr_q    <= '0;
            isr_q    <= '0;
            imr_q    <= '0;
            // Samplers track the live inputs so nothing looks like an edge
            // on the first cycle out of reset.
            irq_q    <= irq_i;
            inta_q   <= inta_i;
            ack_q    <= 1'b0;
            intr_q   <= 1'b0;
            vector_q <= {VECTOR_BASE, 3'b000};
        end else begin
            irq_q  <= irq_i;
            inta_q <= inta_i;
            ack_q  <= bus.wb_stb_i & bus.wb_cyc_i & ~ack_q;
            intr_q <= elig_valid & ~inta_i;
            irr_q  <= irr_d;
            isr_q  <= isr_d;
            if (bus_write && reg_sel == REG_IMR) begin
                imr_q <= bus.wb_dat_i[NUM_IRQ-1:0];
            end
            if (inta_rise) begin
                vector_q <= elig_valid ? {VECTOR_BASE, elig_id}
                                       : {VECTOR_BASE, SPURIOUS_ID};
            end
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign intr_o       = intr_q;
    assign vector_o     = vector_q;

endmodule

// File: tb/tb_wb_pic.sv
// Self-checking bench for wb_pic. Three instances share one stimulus:
//   dut0: NUM_IRQ=2 defaults, dut1: NUM_IRQ=8, dut2: NUM_IRQ=8 AUTO_EOI=1.
// A per-instance model derived from the controller's rules is compared
// against every instance on each falling edge; directed literal checks pin
// the model at the interesting points.
module tb_wb_pic;
    import pic_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        inta;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic        we, stb, cyc;

    logic [2:0]       intr_w;
    logic [2:0][7:0]  vec_w;
    logic [2:0]       ack_w;
    logic [2:0][15:0] dat_w;

    wb_pic_if bus0 ();
    wb_pic_if bus1 ();
    wb_pic_if bus2 ();

    assign bus0.wb_adr_i = adr;  assign bus1.wb_adr_i = adr;  assign bus2.wb_adr_i = adr;
    assign bus0.wb_dat_i = dat;  assign bus1.wb_dat_i = dat;  assign bus2.wb_dat_i = dat;
    assign bus0.wb_we_i  = we;   assign bus1.wb_we_i  = we;   assign bus2.wb_we_i  = we;
    assign bus0.wb_stb_i = stb;  assign bus1.wb_stb_i = stb;  assign bus2.wb_stb_i = stb;
    assign bus0.wb_cyc_i = cyc;  assign bus1.wb_cyc_i = cyc;  assign bus2.wb_cyc_i = cyc;
    assign ack_w[0] = bus0.wb_ack_o;  assign dat_w[0] = bus0.wb_dat_o;
    assign ack_w[1] = bus1.wb_ack_o;  assign dat_w[1] = bus1.wb_dat_o;
    assign ack_w[2] = bus2.wb_ack_o;  assign dat_w[2] = bus2.wb_dat_o;

    wb_pic #(.NUM_IRQ(2)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus0), .irq_i(irq[1:0]),
        .intr_o(intr_w[0]), .inta_i(inta), .vector_o(vec_w[0])
    );
    wb_pic #(.NUM_IRQ(8)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1), .irq_i(irq),
        .intr_o(intr_w[1]), .inta_i(inta), .vector_o(vec_w[1])
    );
    wb_pic #(.NUM_IRQ(8), .AUTO_EOI(1'b1)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus2), .irq_i(irq),
        .intr_o(intr_w[2]), .inta_i(inta), .vector_o(vec_w[2])
    );

    initial forever #5 clk = ~clk;

    // ---------------- model ----------------
    int unsigned NQ [3] = '{2, 8, 8};
    bit          AE [3] = '{1'b0, 1'b0, 1'b1};
    int unsigned m_irr [3], m_isr [3], m_imr [3], m_irq_prev [3], m_vec [3];
    bit          m_intr [3], m_ack [3], m_inta_prev [3];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          cmp_en = 1'b0;
    logic [15:0] rd [3];
    logic [7:0]  av [3];

    function automatic int lowest(input int unsigned v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Pending, unmasked, and above the highest in-service level.
    function automatic int unsigned elig(input int k);
        int          h;
        int unsigned pend;
        h    = lowest(m_isr[k]);
        pend = m_irr[k] & ~m_imr[k];
        if (h < 0) return pend;
        return pend & ((32'd1 << h) - 32'd1);
    endfunction

    function automatic int unsigned model_read(input int k);
        case (adr)
            REG_IRR: return m_irr[k];
            REG_ISR: return m_isr[k];
            REG_IMR: return m_imr[k];
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int unsigned nm, irq_now, el, clr, set, eoi, rise;
            int          id;
            nm      = (32'd1 << NQ[k]) - 32'd1;
            irq_now = 32'(irq) & nm;
            if (rst) begin
                m_irr[k] = 0; m_isr[k] = 0; m_imr[k] = 0;
                m_intr[k] = 1'b0; m_ack[k] = 1'b0; m_vec[k] = 8;
            end else begin
                el = elig(k); clr = 0; set = 0; eoi = 0;
                rise = irq_now & ~m_irq_prev[k];
                if (inta && !m_inta_prev[k]) begin
                    if (el != 0) begin
                        id  = lowest(el);
                        clr = 32'd1 << id;
                        if (!AE[k]) set = 32'd1 << id;
                        m_vec[k] = 32'd8 + 32'(id);
                    end else begin
                        m_vec[k] = 15;
                    end
                end
                if (m_ack[k] && stb && cyc && we) begin
                    if (adr == REG_IMR) m_imr[k] = 32'(dat) & nm;
                    if (adr == REG_EOI) begin
                        if (dat[15]) begin
                            if (32'(dat[2:0]) < NQ[k]) eoi = 32'd1 << dat[2:0];
                        end else if (m_isr[k] != 0) begin
                            eoi = 32'd1 << lowest(m_isr[k]);
                        end
                    end
                end
                m_intr[k] = (el != 0) && !inta;
                m_ack[k]  = stb && cyc && !m_ack[k];
                m_irr[k]  = (m_irr[k] & ~clr) | rise;
                m_isr[k]  = (m_isr[k] & ~eoi) | set;
            end
            m_irq_prev[k]  = irq_now;
            m_inta_prev[k] = inta;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("intr_o[dut%0d]", k), 32'(intr_w[k]), 32'(m_intr[k]));
            chk($sformatf("vector_o[dut%0d]", k), 32'(vec_w[k]), m_vec[k]);
            chk($sformatf("wb_ack_o[dut%0d]", k), 32'(ack_w[k]), 32'(m_ack[k]));
            if (m_ack[k] && !we)
                chk($sformatf("wb_dat_o[dut%0d]", k), 32'(dat_w[k]), model_read(k));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) compare_all();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input reg_off_e a);
        adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) rd[k] = dat_w[k];
        tick();
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic bus_wr(input reg_off_e a, input logic [15:0] d, input bit with_inta);
        adr = a; dat = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        tick();
        if (with_inta) inta = 1'b1;
        tick();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq = m; tick();
        irq = '0; tick();
    endtask

    task automatic ack_seq();
        inta = 1'b1; tick();
        for (int k = 0; k < 3; k++) av[k] = vec_w[k];
        tick();
        inta = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1; irq = '0; inta = 1'b0; adr = '0; dat = '0;
        we = 1'b0; stb = 1'b0; cyc = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_vector", 32'(vec_w[1]), 32'h08);
        chk("rst_intr",   32'(intr_w[1]), 32'h0);
        chk("rst_ack",    32'(ack_w[1]), 32'h0);
        rst = 1'b0;
        tick();

        // Single level on the 2-input instance.
        pulse(8'h02);
        chk("r036_intr", 32'(intr_w[0]), 32'h1);
        bus_rd(REG_IRR);
        chk("r036_irr_before", 32'(rd[0]), 32'h2);
        inta = 1'b1; tick();
        chk("r036_vector", 32'(vec_w[0]), 32'h09);
        chk("r036_intr_drop", 32'(intr_w[0]), 32'h0);
        tick(); inta = 1'b0; tick();
        bus_rd(REG_ISR);
        chk("r036_isr", 32'(rd[0]), 32'h2);
        chk("auto_eoi_isr_a", 32'(rd[2]), 32'h0);
        bus_rd(REG_IRR);
        chk("r036_irr_after", 32'(rd[0]), 32'h0);
        bus_wr(REG_EOI, 16'h0000, 1'b0);

        // Nesting.
        pulse(8'h10); ack_seq();
        chk("nest_vec4", 32'(av[1]), 32'h0C);
        pulse(8'h40);
        chk("nest_low_blocked", 32'(intr_w[1]), 32'h0);
        pulse(8'h04);
        chk("nest_high_intr", 32'(intr_w[1]), 32'h1);
        ack_seq();
        chk("nest_vec2", 32'(av[1]), 32'h0A);
        bus_rd(REG_ISR);
        chk("nest_isr", 32'(rd[1]), 32'h14);
        bus_wr(REG_EOI, 16'h0000, 1'b0);
        bus_rd(REG_ISR);
        chk("nest_isr_eoi", 32'(rd[1]), 32'h10);
        bus_wr(REG_EOI, 16'h0000, 1'b0);
        tick(); tick();
        ack_seq();
        chk("nest_vec6", 32'(av[1]), 32'h0E);
        bus_wr(REG_EOI, 16'h0000, 1'b0);

        // Masking.
        bus_wr(REG_IMR, 16'h0001, 1'b0);
        pulse(8'h01);
        bus_rd(REG_IRR);
        chk("mask_irr", 32'(rd[1]), 32'h01);
        chk("mask_intr", 32'(intr_w[1]), 32'h0);
        bus_wr(REG_IMR, 16'h0000, 1'b0);
        tick();
        chk("unmask_intr", 32'(intr_w[1]), 32'h1);
        ack_seq();
        bus_wr(REG_EOI, 16'h0000, 1'b0);

        // EOI variants.
        pulse(8'h04); ack_seq();
        pulse(8'h01); ack_seq();
        bus_rd(REG_ISR);
        chk("eoi_isr05", 32'(rd[1]), 32'h05);
        bus_wr(REG_EOI, 16'h0000, 1'b0);
        bus_rd(REG_ISR);
        chk("eoi_nonspec", 32'(rd[1]), 32'h04);
        bus_wr(REG_EOI, 16'h8002, 1'b0);
        bus_rd(REG_ISR);
        chk("eoi_spec2", 32'(rd[1]), 32'h00);
        bus_wr(REG_EOI, 16'h8009, 1'b0);
        bus_rd(REG_ISR);
        chk("eoi_8009", 32'(rd[1]), 32'h00);
        pulse(8'h02); ack_seq();
        bus_wr(REG_EOI, 16'h8002, 1'b0);
        bus_rd(REG_ISR);
        chk("eoi_range_ignored", 32'(rd[0]), 32'h2);
        bus_wr(REG_EOI, 16'h8001, 1'b0);
        bus_rd(REG_ISR);
        chk("eoi_spec1", 32'(rd[0]), 32'h0);

        // Spurious acknowledge and AUTO_EOI.
        ack_seq();
        chk("spur_vec8", 32'(av[1]), 32'h0F);
        chk("spur_vec2", 32'(av[0]), 32'h0F);
        bus_rd(REG_IRR);
        chk("spur_irr", 32'(rd[1]), 32'h0);
        bus_rd(REG_ISR);
        chk("spur_isr", 32'(rd[1]), 32'h0);
        pulse(8'h08); ack_seq();
        chk("auto_vec3", 32'(av[2]), 32'h0B);
        bus_rd(REG_ISR);
        chk("auto_isr", 32'(rd[2]), 32'h0);
        chk("noauto_isr", 32'(rd[1]), 32'h08);

        // Edge racing its own acknowledge: the edge wins.
        pulse(8'h02);
        irq = 8'h02; inta = 1'b1; tick();
        irq = '0; tick();
        inta = 1'b0; tick();
        bus_rd(REG_IRR);
        chk("race_irr", 32'(rd[1]), 32'h02);
        bus_rd(REG_ISR);
        chk("race_isr", 32'(rd[1]), 32'h0A);

        // EOI of one level coinciding with acknowledge of another.
        bus_wr(REG_EOI, 16'h0000, 1'b0);
        tick(); tick();
        bus_wr(REG_EOI, 16'h0000, 1'b1);
        tick();
        inta = 1'b0; tick();
        bus_rd(REG_ISR);
        chk("eoi_ack_same", 32'(rd[1]), 32'h02);
        bus_wr(REG_EOI, 16'h0000, 1'b0);

        // Reset in the middle of an acknowledge and a bus cycle.
        pulse(8'h02); ack_seq();
        pulse(8'h01); ack_seq();
        bus_wr(REG_IMR, 16'h00F0, 1'b0);
        bus_rd(REG_ISR);
        chk("prerst_isr", 32'(rd[1]), 32'h03);
        inta = 1'b1; adr = REG_ISR; we = 1'b0; stb = 1'b1; cyc = 1'b1; rst = 1'b1;
        tick();
        chk("rst_mid_intr", 32'(intr_w[1]), 32'h0);
        chk("rst_mid_ack",  32'(ack_w[1]), 32'h0);
        chk("rst_mid_vec",  32'(vec_w[1]), 32'h08);
        tick();
        rst = 1'b0; stb = 1'b0; cyc = 1'b0;
        tick();
        bus_rd(REG_IRR);
        chk("postrst_irr", 32'(rd[1]), 32'h0);
        bus_rd(REG_ISR);
        chk("postrst_isr", 32'(rd[1]), 32'h0);
        bus_rd(REG_IMR);
        chk("postrst_imr", 32'(rd[1]), 32'h0);
        inta = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
